nv_ram_rwsp_128x11_fifo_ctrl: RTL



---
 rtl/nv_ram_rwsp_128x11_fifo_ctrl_if.sv | 35 +++
 rtl/nv_ram_rwsp_128x11_fifo_ctrl.sv | 96 +++++++++
 2 files changed

// File: rtl/nv_ram_rwsp_128x11_fifo_ctrl_if.sv
// Signal bundle between the 128x11 RAM FIFO controller, its producer/consumer and the RAM macro.
// The controller takes the slave view; the surrounding logic drives through the master view.
interface nv_ram_rwsp_128x11_fifo_ctrl_if #(
    parameter int AW = 7,
    parameter int DW = 11
);
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic [31:0]   pwrbus_ram_pd_in;
    logic [31:0]   pwrbus_ram_pd;
    logic [AW:0]   wr_count;

    modport master (
        output wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd_in,
        input  wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra,
               ram_re, ram_ore, pwrbus_ram_pd, wr_count
    );

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy, ram_dout, pwrbus_ram_pd_in,
        output wr_prdy, rd_pvld, rd_pd, ram_wa, ram_we, ram_di, ram_ra,
               ram_re, ram_ore, pwrbus_ram_pd, wr_count
    );
endinterface

// File: rtl/nv_ram_rwsp_128x11_fifo_ctrl.sv
// Valid/ready FIFO control around an external two-port RAM with registered read address
// (re) and registered read data (ore); the two read registers are tracked as stages p1/p2.
module nv_ram_rwsp_128x11_fifo_ctrl #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 11
) (
    input  logic clk,
    input  logic rst,
    nv_ram_rwsp_128x11_fifo_ctrl_if.slave bus
);

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occupancy;
    logic [AW:0]   avail;
    logic          vld_p1;
    logic          vld_p2;

    logic          wr_rdy;
    logic          wr_acc;
    logic          rd_acc;
    logic          re;
    logic          ore;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Write side: ready depends only on registered occupancy, never on rd_prdy.
    assign wr_rdy  = (occupancy != FULL_LVL);
    assign wr_acc  = bus.wr_pvld & wr_rdy;
    assign wr_data = bus.wr_pd;

    // p1 -> p2 advance when the output register is free or being drained this cycle;
    // a new address issues into p1 when there is unissued data and p1 is free or advancing.
    assign ore    = vld_p1 & (~vld_p2 | bus.rd_prdy);
    assign re     = (avail != '0) & (~vld_p1 | ore);
    assign rd_acc = vld_p2 & bus.rd_prdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            avail     <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (re)     rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   occupancy <= occupancy + CNT_ONE;
                2'b01:   occupancy <= occupancy - CNT_ONE;
                default: occupancy <= occupancy;
            endcase
            case ({wr_acc, re})
                2'b10:   avail <= avail + CNT_ONE;
                2'b01:   avail <= avail - CNT_ONE;
                default: avail <= avail;
            endcase
        end
    end

    // Stage p1: address in the RAM read-address register
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= re | (vld_p1 & ~ore);
    end

    // Stage p2: data in the RAM output register, presented to the consumer
    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= ore | (vld_p2 & ~bus.rd_prdy);
    end

    assign rd_data = bus.ram_dout;

    assign bus.wr_prdy       = wr_rdy;
    assign bus.ram_we        = wr_acc;
    assign bus.ram_wa        = wr_ptr;
    assign bus.ram_di        = wr_data;
    assign bus.ram_ra        = rd_ptr;
    assign bus.ram_re        = re;
    assign bus.ram_ore       = ore;
    assign bus.rd_pvld       = vld_p2;
    assign bus.rd_pd         = rd_data;
    assign bus.wr_count      = occupancy;
    assign bus.pwrbus_ram_pd = bus.pwrbus_ram_pd_in;

endmodule
